// File: rtl/axi_lite_protocol_checker.sv
// Passive AXI4-Lite protocol monitor: checks payload stability, orphan responses,
// outstanding-transaction overflow and handshake timeouts; reports pulse, sticky and first error.
module axi_lite_protocol_checker #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 256
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    input  logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    input  logic                rready,
    input  logic                clear_err,
    output logic [8:0]          err_pulse,
    output logic [8:0]          err_sticky,
    output logic [3:0]          first_err,
    output logic                first_err_valid,
    output logic [15:0]         wr_done_cnt,
    output logic [15:0]         rd_done_cnt
);

    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned PEND_W  = 4;
    localparam int unsigned NUM_ERR = 9;
    localparam int unsigned NUM_CH  = 5;
    localparam int unsigned TO_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    logic [ADDR_W-1:0] awaddr_q, araddr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [NUM_CH-1:0] stall_q;
    logic [NUM_CH-1:0] stall_now;
    logic [PEND_W-1:0] aw_pend, w_pend, rd_pend;
    logic [TO_W-1:0]   wait_q [NUM_CH];
    logic [NUM_ERR-1:0] err_now;
    logic [3:0]        first_idx;
    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic              b_orphan, r_orphan, timeout_hit;

    // Saturating pending counter; a decrement at zero is dropped (orphan response)
    function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] cnt,
                                                     input logic inc, input logic dec);
        logic dec_ok;
        logic [PEND_W-1:0] nxt;
        dec_ok = dec && (cnt != '0);
        nxt    = cnt;
        if (inc && !dec_ok && (cnt != PEND_W'(MAX_OUTSTANDING)))
            nxt = cnt + PEND_W'(1);
        else if (dec_ok && !inc)
            nxt = cnt - PEND_W'(1);
        return nxt;
    endfunction

    function automatic logic pend_ovf(input logic [PEND_W-1:0] cnt, input logic inc, input logic dec);
        return inc && !(dec && (cnt != '0)) && (cnt == PEND_W'(MAX_OUTSTANDING));
    endfunction

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid  && wready;
    assign b_hs  = bvalid  && bready;
    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid  && rready;

    assign stall_now = {rvalid && !rready, arvalid && !arready, bvalid && !bready,
                        wvalid && !wready, awvalid && !awready};

    // Registered counts only, so a same-cycle AW/W/AR handshake cannot legalise a response
    assign b_orphan = bvalid && ((aw_pend == '0) || (w_pend == '0));
    assign r_orphan = rvalid && (rd_pend == '0);

    always_comb begin
        timeout_hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((TIMEOUT_CYCLES != 0) && stall_now[i] && (wait_q[i] == TO_W'(TO_LAST)))
                timeout_hit = 1'b1;
        end
    end

    always_comb begin
        err_now    = '0;
        err_now[0] = stall_q[0] && (!awvalid || (awaddr != awaddr_q));
        err_now[1] = stall_q[1] && (!wvalid || (wdata != wdata_q) || (wstrb != wstrb_q));
        err_now[2] = stall_q[2] && (!bvalid || (bresp != bresp_q));
        err_now[3] = stall_q[3] && (!arvalid || (araddr != araddr_q));
        err_now[4] = stall_q[4] && (!rvalid || (rdata != rdata_q) || (rresp != rresp_q));
        err_now[5] = b_orphan;
        err_now[6] = r_orphan;
        err_now[7] = pend_ovf(aw_pend, aw_hs, b_hs) || pend_ovf(w_pend, w_hs, b_hs)
                  || pend_ovf(rd_pend, ar_hs, r_hs);
        err_now[8] = timeout_hit;
    end

    // Lowest set index wins
    always_comb begin
        first_idx = '0;
        for (int i = 0; i < NUM_ERR; i++) begin
            if (err_now[NUM_ERR-1-i])
                first_idx = 4'(NUM_ERR - 1 - i);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            awaddr_q        <= '0;
            araddr_q        <= '0;
            wdata_q         <= '0;
            rdata_q         <= '0;
            wstrb_q         <= '0;
            bresp_q         <= '0;
            rresp_q         <= '0;
            stall_q         <= '0;
            aw_pend         <= '0;
            w_pend          <= '0;
            rd_pend         <= '0;
            for (int i = 0; i < NUM_CH; i++) wait_q[i] <= '0;
            err_pulse       <= '0;
            err_sticky      <= '0;
            first_err       <= '0;
            first_err_valid <= 1'b0;
            wr_done_cnt     <= '0;
            rd_done_cnt     <= '0;
        end else begin
            awaddr_q <= awaddr;
            araddr_q <= araddr;
            wdata_q  <= wdata;
            rdata_q  <= rdata;
            wstrb_q  <= wstrb;
            bresp_q  <= bresp;
            rresp_q  <= rresp;
            stall_q  <= stall_now;
            aw_pend  <= pend_next(aw_pend, aw_hs, b_hs);
            w_pend   <= pend_next(w_pend, w_hs, b_hs);
            rd_pend  <= pend_next(rd_pend, ar_hs, r_hs);
            for (int i = 0; i < NUM_CH; i++) begin
                if (!stall_now[i])
                    wait_q[i] <= '0;
                else if (wait_q[i] != TO_W'(TIMEOUT_CYCLES))
                    wait_q[i] <= wait_q[i] + TO_W'(1);
            end
            err_pulse  <= err_now;
            err_sticky <= (clear_err ? '0 : err_sticky) | err_now;
            // A violation coinciding with clear_err becomes the new first error
            if ((err_now != '0) && (!first_err_valid || clear_err)) begin
                first_err       <= first_idx;
                first_err_valid <= 1'b1;
            end else if (clear_err) begin
                first_err       <= '0;
                first_err_valid <= 1'b0;
            end
            if (b_hs && !b_orphan) wr_done_cnt <= wr_done_cnt + 16'd1;
            if (r_hs && !r_orphan) rd_done_cnt <= rd_done_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_axi_lite_protocol_checker.sv
// Scoreboard bench for axi_lite_protocol_checker: stimulus queues hand-computed
// expectations tagged with the cycle they apply to; a negedge monitor pops and compares.
module tb_axi_lite_protocol_checker;

    localparam int K_PULSE  = 0;
    localparam int K_STICKY = 1;
    localparam int K_FIRST  = 2;
    localparam int K_WR     = 3;
    localparam int K_RD     = 4;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, clear_err;
    logic [8:0]  err_pulse, err_sticky;
    logic [3:0]  first_err;
    logic        first_err_valid;
    logic [15:0] wr_done_cnt, rd_done_cnt;

    typedef struct {
        int          tgt;
        int          kind;
        logic [15:0] val;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    axi_lite_protocol_checker #(
        .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .clear_err(clear_err),
        .err_pulse(err_pulse), .err_sticky(err_sticky),
        .first_err(first_err), .first_err_valid(first_err_valid),
        .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in the current cycle
    always @(negedge aclk) begin
        chk_t        e;
        logic [15:0] act;
        while (sb.size() != 0 && sb[0].tgt <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                K_PULSE:  act = {7'd0, err_pulse};
                K_STICKY: act = {7'd0, err_sticky};
                K_FIRST:  act = {11'd0, first_err_valid, first_err};
                K_WR:     act = wr_done_cnt;
                default:  act = rd_done_cnt;
            endcase
            checks++;
            if (e.tgt != cyc || act != e.val) begin
                errors++;
                $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h", e.name, cyc, e.tgt, act, e.val);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sb.size());
        $fatal(1, "watchdog expired");
    end

    // Expectation for the outputs visible after the next rising edge
    task automatic exp_chk(input int kind, input logic [15:0] val, input string name);
        chk_t e;
        e.tgt  = cyc + 1;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        areset = 1'b1; clear_err = 1'b0;
        awaddr = '0; awvalid = 0; awready = 0;
        wdata = '0; wstrb = '0; wvalid = 0; wready = 0;
        bresp = '0; bvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; arready = 0;
        rdata = '0; rresp = '0; rvalid = 0; rready = 0;
        step();
        exp_chk(K_PULSE, 16'h0, "rst_pulse");
        exp_chk(K_STICKY, 16'h0, "rst_sticky");
        exp_chk(K_FIRST, 16'h0, "rst_first");
        exp_chk(K_WR, 16'h0, "rst_wr");
        exp_chk(K_RD, 16'h0, "rst_rd");
        step();
        areset = 1'b0;

        // AW address changes while stalled
        awvalid = 1; awaddr = 32'h1000; step(); step();
        awaddr = 32'h1004;
        exp_chk(K_PULSE, 16'h001, "aw_stable_pulse");
        exp_chk(K_FIRST, 16'h010, "aw_first");
        step();
        awready = 1;
        exp_chk(K_PULSE, 16'h000, "aw_pulse_once");
        exp_chk(K_STICKY, 16'h001, "aw_sticky");
        step();
        awvalid = 0; awready = 0; step();

        clear_err = 1;
        exp_chk(K_STICKY, 16'h000, "clear_sticky");
        exp_chk(K_FIRST, 16'h000, "clear_first");
        step();
        clear_err = 0;

        // W then B completes the write; a second B is orphaned
        wvalid = 1; wready = 1; wdata = 32'hA5A5_0001; wstrb = 4'hF; step();
        wvalid = 0; wready = 0;
        bvalid = 1; bready = 1;
        exp_chk(K_PULSE, 16'h000, "b_ok_pulse");
        exp_chk(K_WR, 16'h0001, "b_ok_wr");
        step();
        exp_chk(K_PULSE, 16'h020, "b_orphan_pulse");
        exp_chk(K_WR, 16'h0001, "b_orphan_wr");
        step();
        bvalid = 0; bready = 0;
        exp_chk(K_PULSE, 16'h000, "b_orphan_once");
        exp_chk(K_FIRST, 16'h015, "b_orphan_first");
        step();

        // Five reads without responses overflow at the fifth
        arvalid = 1; arready = 1; araddr = 32'h40;
        for (int i = 0; i < 5; i++) begin
            exp_chk(K_PULSE, (i == 4) ? 16'h080 : 16'h000, "ar_ovf_pulse");
            step();
        end
        arvalid = 0; arready = 0;
        rvalid = 1; rready = 1;
        for (int i = 0; i < 4; i++) begin
            rdata = 32'h100 + 32'(i);
            exp_chk(K_PULSE, 16'h000, "r_drain_pulse");
            exp_chk(K_RD, 16'(i + 1), "r_drain_rd");
            step();
        end
        exp_chk(K_PULSE, 16'h040, "r_orphan_pulse");
        exp_chk(K_RD, 16'h0004, "r_orphan_rd");
        step();
        rvalid = 0; rready = 0;
        exp_chk(K_STICKY, 16'h0E0, "sticky_accum");
        exp_chk(K_FIRST, 16'h015, "first_held");
        step();

        // AR stalled 20 cycles: one timeout after the 8th waiting cycle
        arvalid = 1; arready = 0; araddr = 32'h80;
        for (int k = 1; k <= 20; k++) begin
            exp_chk(K_PULSE, (k == 8) ? 16'h100 : 16'h000, "ar_timeout_pulse");
            step();
        end
        arready = 1;
        exp_chk(K_PULSE, 16'h000, "ar_stall_done");
        step(); step(); step();
        arvalid = 0; arready = 0;

        // Reset with three reads pending and AW stalled
        areset = 1; awvalid = 1; awready = 0; awaddr = 32'h2000;
        exp_chk(K_PULSE, 16'h000, "rst2_pulse");
        exp_chk(K_STICKY, 16'h000, "rst2_sticky");
        exp_chk(K_FIRST, 16'h000, "rst2_first");
        exp_chk(K_WR, 16'h0000, "rst2_wr");
        exp_chk(K_RD, 16'h0000, "rst2_rd");
        step();
        areset = 0; awaddr = 32'h3000; rvalid = 1; rready = 1;
        exp_chk(K_PULSE, 16'h040, "rst2_orphan_r_no_stab");
        exp_chk(K_FIRST, 16'h016, "rst2_first_r");
        step();
        awready = 1; rvalid = 0; rready = 0;
        exp_chk(K_PULSE, 16'h000, "rst2_aw_hs");
        exp_chk(K_RD, 16'h0000, "rst2_rd_after");
        step();
        awvalid = 0; awready = 0;

        // W drops valid while stalled
        wvalid = 1; wready = 0; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; step();
        wvalid = 0;
        exp_chk(K_PULSE, 16'h002, "w_stable_pulse");
        exp_chk(K_STICKY, 16'h042, "w_stable_sticky");
        exp_chk(K_FIRST, 16'h016, "w_first_held");
        step();

        // 65536 reads wrap the completion counter
        arvalid = 1; arready = 1; araddr = 32'h0; step();
        rvalid = 1; rready = 1;
        for (int n = 1; n <= 65536; n++) begin
            if (n == 65535) exp_chk(K_RD, 16'hFFFF, "rd_cnt_max");
            if (n == 65536) begin
                exp_chk(K_RD, 16'h0000, "rd_cnt_wrap");
                exp_chk(K_PULSE, 16'h000, "rd_wrap_pulse");
            end
            step();
        end
        arvalid = 0; arready = 0; rvalid = 0; rready = 0;
        step(); step(); step();

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_protocol_checker.md
AXI_LITE_PROTOCOL_CHECKER -- requirements
Module: axi_lite_protocol_checker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter ADDR_W, default 32, address width of awaddr/araddr.
REQ-003 Parameter DATA_W, default 32, width of wdata/rdata; wstrb width is DATA_W/8.
REQ-004 Parameter MAX_OUTSTANDING, default 4, maximum pending transactions per direction (range 1..15).
REQ-005 Parameter TIMEOUT_CYCLES, default 256, maximum cycles of valid without ready; 0 disables the timeout check.
REQ-006 aclk  input  1  clock; all logic on posedge.
REQ-007 areset  input  1  synchronous active-high reset.
REQ-008 awaddr/awvalid/awready  input  ADDR_W/1/1  write address channel, monitored only.
REQ-009 wdata/wstrb/wvalid/wready  input  DATA_W/DATA_W/8/1/1  write data channel, monitored only.
REQ-010 bresp/bvalid/bready  input  2/1/1  write response channel, monitored only.
REQ-011 araddr/arvalid/arready  input  ADDR_W/1/1  read address channel, monitored only.
REQ-012 rdata/rresp/rvalid/rready  input  DATA_W/2/1/1  read data channel, monitored only.
REQ-013 clear_err  input  1  clears sticky errors and first-error capture.
REQ-014 err_pulse  output  9  one-cycle flag per violation class.
REQ-015 err_sticky  output  9  accumulated violations.
REQ-016 first_err  output  4  bit index of the first violation since reset or clear; first_err_valid  output  1.
REQ-017 wr_done_cnt, rd_done_cnt  output  16 each  completed B and R handshakes.

Function
REQ-018 A handshake SHALL occur on a channel in any cycle where valid && ready at posedge aclk.
REQ-019 Error bits: 0 AW stable, 1 W stable, 2 B stable, 3 AR stable, 4 R stable, 5 orphan B, 6 orphan R, 7 outstanding overflow, 8 timeout.
REQ-020 Stability: if valid && !ready in cycle N, then in cycle N+1 valid SHALL be 1 and every payload signal (addr; wdata+wstrb; bresp; rdata+rresp) SHALL equal its cycle-N value; otherwise that channel's bit is set.
REQ-021 Payload is registered every cycle; the comparison applies only to cycles following valid && !ready.
REQ-022 Write counters aw_pend and w_pend (0..MAX_OUTSTANDING) SHALL increment on AW and W handshakes respectively; both SHALL decrement on a B handshake.
REQ-023 Orphan B (bit 5): bvalid while aw_pend==0 or w_pend==0, using registered values, so an AW/W handshake in the same cycle does not legalise it.
REQ-024 rd_pend SHALL increment on an AR handshake and decrement on an R handshake; orphan R (bit 6): rvalid while rd_pend==0.
REQ-025 On an orphan handshake the counters SHALL NOT decrement below 0.
REQ-026 Overflow (bit 7): an increment with a counter at MAX_OUTSTANDING and no same-cycle decrement; the counter saturates.
REQ-027 An increment and a decrement in the same cycle SHALL leave the count unchanged.
REQ-028 Timeout (bit 8): each channel has a wait counter that counts cycles of valid && !ready and clears otherwise; the bit is set when any counter reaches TIMEOUT_CYCLES, once per stall, and the counter saturates.
REQ-029 Latency: a violation in the sample at edge N SHALL assert err_pulse at edge N+1 for exactly one cycle; err_sticky SHALL be set at the same edge.
REQ-030 first_err SHALL capture the lowest set index of the first nonzero err_pulse; it holds until reset or clear_err.
REQ-031 clear_err SHALL zero err_sticky and first_err_valid at the next edge; a violation in the same cycle wins and is captured.
REQ-032 wr_done_cnt/rd_done_cnt SHALL increment on non-orphan B/R handshakes and wrap from 0xFFFF to 0.
REQ-033 Outputs are pure functions of registered state; no combinational input-to-output path.

Reset
REQ-034 While areset=1 at posedge, all counters, registered payload copies, err_pulse, err_sticky, first_err (0) and first_err_valid SHALL clear, and no checks fire.
REQ-035 Asserting areset mid-transaction SHALL discard all pending counts; the first cycle after deassertion is not checked for stability.

Verification
REQ-036 awvalid=1, awaddr=0x1000, awready=0 for 2 cycles, then awaddr=0x1004 -> err_pulse[0]=1 one cycle later, first_err=0.
REQ-037 AW, W, then B handshakes with MAX_OUTSTANDING=4 -> no errors, wr_done_cnt=1; bvalid with no prior AW -> err_pulse[5].
REQ-038 Five AR handshakes with no R and MAX_OUTSTANDING=4 -> err_pulse[7] on the fifth, rd_pend=4.
REQ-039 TIMEOUT_CYCLES=8, arvalid=1, arready=0 for 20 cycles -> a single err_pulse[8] after 8 waiting cycles.
REQ-040 Sticky error present, clear_err pulse -> err_sticky=0, first_err_valid=0; reset mid-burst with rd_pend=3 -> rd_pend=0 and a following rvalid flags orphan R.
REQ-041 65536 reads -> rd_done_cnt wraps to 0.
